booth_signed_divider: RTL and testbench
=======================================

// Module: booth_signed_divider
// PURPOSE
//  Sequential signed (two's-complement) integer divider. It is the inverse-operation
//  companion to the Booth multiplier: it reuses the same start/iterate/done control style.
//  Uses restoring division on operand magnitudes, then applies sign correction.
//  Quotient truncates toward zero; the remainder takes the dividend's sign.
//  Sits beside the multiplier in the arithmetic unit and shares its start convention.
// PARAMETERS
//  WIDTH    4   operand/result width in bits (two's complement), >= 2
// PORTS
//  i_clk         in   1      rising-edge clock
//  i_rst         in   1      synchronous reset, active-high
//  start         in   1      request; sampled only in IDLE
//  dividend      in   WIDTH  signed dividend, captured on accepted start
//  divisor       in   WIDTH  signed divisor, captured on accepted start
//  quotient      out  WIDTH  signed quotient, held after done
//  remainder     out  WIDTH  signed remainder, held after done
//  busy          out  1      high from LOAD through FIX
//  done          out  1      one-cycle pulse, asserted while results become valid
//  overflow      out  1      quotient not representable (MIN / -1), held with results
//  div_by_zero   out  1      divisor==0 detected (macro-gated), held with results
// BEHAVIOUR
//  Reset:
//   - All outputs are 0. State goes to IDLE.
//   - A reset mid-operation aborts the operation. The captured operands are discarded.
//  States: IDLE -> LOAD -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
//  IDLE:
//   - When start=1, capture the operands and go to LOAD. Otherwise stay in IDLE.
//   - Previous results remain on the outputs.
//  LOAD:
//   - Set R=0 (WIDTH+1 bits) and Qm=|dividend| (WIDTH bits, unsigned).
//   - Set D=|divisor| (WIDTH bits, unsigned).
//   - Latch sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
//   - Clear the iteration counter and the sticky flags.
//  ITER, once per cycle, for WIDTH cycles:
//   - Shift {R,Qm} left by 1 and compute T = R - D.
//   - If T >= 0: R=T and Qm[0]=1. Else: R is unchanged (restored) and Qm[0]=0.
//   - The counter reaches WIDTH-1, then the state moves to FIX.
//  FIX:
//   - quotient = sign_q ? -Qm : Qm. remainder = sign_r ? -R : R (truncated to WIDTH bits).
//   - overflow = 1 iff sign_q=0 and Qm[MSB]=1. This occurs only for MIN / -1.
//     In that case quotient = MIN (wrapped).
//  DONE: done=1 for exactly one cycle, then return to IDLE.
//   - start is evaluated again in IDLE only; back-to-back operations have a 1-cycle gap.
//  Latency and busy:
//   - With start accepted at cycle 0, done is asserted at cycle WIDTH+3.
//   - busy=1 for cycles 1..WIDTH+2.
//   - start while busy or in DONE is ignored, with no queueing.
//  Edge cases:
//   - Operands may change freely after capture.
//   - 0 / x gives q=0, r=0.
//   - |dividend| < |divisor| gives q=0, r=dividend.
// CONFIGURATION
//  `DIV_ZERO_DETECT_EN defined:
//   - In LOAD, divisor==0 sets div_by_zero=1 and skips ITER; the state goes straight to FIX.
//   - FIX forces quotient = all ones (-1) and remainder = dividend, with overflow=0.
//   - done is asserted at cycle 3.
//  `DIV_ZERO_DETECT_EN undefined:
//   - div_by_zero is tied to 0 and divisor==0 runs the normal algorithm.
//   - Result: Qm = all ones, then sign-corrected; remainder = dividend.
//   - done is asserted at cycle WIDTH+3.
// STRUCTURE
//  Shared package div_pkg:
//   - state encodings (IDLE=0, LOAD=1, ITER=2, FIX=3, DONE=4, 3-bit)
//   - control-vector bit positions for the datapath enables
//  Sub-module div_datapath:
//   - holds R, Qm, D and the subtract/restore/shift logic
//   - driven by load/iter/fix enables from the FSM in this module
// TESTING (WIDTH=4)
//  7 / 2 -> q=3, r=1, overflow=0; done at exactly cycle 7 after start.
//  -7 / 2 -> q=-3 (4'hD), r=-1 (4'hF); 7 / -2 -> q=-3, r=1; -7 / -2 -> q=3, r=-1.
//  -8 / -1 -> q=-8 (4'h8), r=0, overflow=1; -8 / 1 -> q=-8, overflow=0.
//  5 / 0:
//   - with macro: div_by_zero=1, q=4'hF, r=5, done at cycle 3.
//   - without macro: div_by_zero=0, done at cycle 7.
//  Assert start every cycle during an operation -> no re-capture; busy contiguous;
//   exactly one done per accepted start.
//  Assert i_rst=1 at cycle 4 of 6 / 3 -> next cycle all outputs 0, IDLE;
//   a new 6 / 3 then gives q=2, r=0.
// ---------------------------------------------------------------------------

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding
// and bit positions of the control vector that drives the datapath.
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int CTL_LOAD = 0;
  localparam int CTL_ITER = 1;
  localparam int CTL_FIX  = 2;
  localparam int CTL_W    = 3;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: works on operand magnitudes (R, Qm, D) and
// applies the sign correction when the FSM raises the fix enable.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CTL_W-1:0] ctl_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             dbz_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             overflow_o
);

  // Magnitude of a two's-complement value; MIN maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] qm_q, qm_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] qm_sh;
  logic [WIDTH+1:0] trial;

  // One restoring step, load of magnitudes, and final sign correction.
  always_comb begin
    r_d    = r_q;
    qm_d   = qm_q;
    d_d    = d_q;
    negq_d = negq_q;
    negr_d = negr_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    ovf_d  = ovf_q;
    r_sh   = {r_q[WIDTH-1:0], qm_q[WIDTH-1]};
    qm_sh  = {qm_q[WIDTH-2:0], 1'b0};
    // R stays below 2^WIDTH, so the extra top bit is a clean sign of R - D.
    trial  = {1'b0, r_sh} - {2'b00, d_q};
    if (ctl_i[CTL_LOAD]) begin
      r_d    = '0;
      qm_d   = mag(op_a_i);
      d_d    = mag(op_b_i);
      negq_d = op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
      negr_d = op_a_i[WIDTH-1];
    end else if (ctl_i[CTL_ITER]) begin
      if (trial[WIDTH+1]) begin
        r_d  = r_sh;
        qm_d = qm_sh;
      end else begin
        r_d  = trial[WIDTH:0];
        qm_d = qm_sh | {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else if (ctl_i[CTL_FIX]) begin
      if (dbz_i) begin
        quo_d = '1;
        rem_d = op_a_i;
        ovf_d = 1'b0;
      end else begin
        quo_d = negq_q ? -qm_q : qm_q;
        rem_d = negr_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        // A positive quotient with its MSB set only arises from MIN / -1.
        ovf_d = ~negq_q & qm_q[WIDTH-1];
      end
    end
  end

  // Datapath and result registers; reset clears results so outputs read 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= '0;
      qm_q   <= '0;
      d_q    <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      qm_q   <= qm_d;
      d_q    <= d_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      ovf_q  <= ovf_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/booth_signed_divider.sv
// Sequential signed divider, IDLE -> LOAD -> ITER x WIDTH -> FIX -> DONE.
// Quotient truncates toward zero; remainder carries the dividend's sign.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips the iterations and
// returns quotient -1, remainder = dividend, with div_by_zero raised.
module booth_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             dbz_q, dbz_d;
  logic             dbz_hit;
  logic [CTL_W-1:0] ctl;

`ifdef DIV_ZERO_DETECT_EN
  assign dbz_hit = (b_q == '0);
`else
  assign dbz_hit = 1'b0;
`endif

  // Next-state, operand capture and datapath enables.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dbz_d   = dbz_q;
    ctl     = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy          = 1'b1;
        ctl[CTL_LOAD] = 1'b1;
        cnt_d         = '0;
        dbz_d         = dbz_hit;
        state_d       = dbz_hit ? ST_FIX : ST_ITER;
      end
      ST_ITER: begin
        busy          = 1'b1;
        ctl[CTL_ITER] = 1'b1;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy         = 1'b1;
        ctl[CTL_FIX] = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any operation and drops captured operands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .ctl_i       (ctl),
    .op_a_i      (a_q),
    .op_b_i      (b_q),
    .dbz_i       (dbz_q),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_booth_signed_divider.sv
// Directed bench for booth_signed_divider at WIDTH=4.
module tb_booth_signed_divider;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  booth_signed_divider #(.WIDTH(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Launch one division from IDLE; returns the done cycle (start edge = 0)
  // and how many cycles busy was high before done.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       output int cyc, output int bcnt);
    @(posedge i_clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge i_clk); #1;
    start = 1'b0; dividend = 4'h0; divisor = 4'h0;
    cyc = 1; bcnt = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (busy === 1'b1) bcnt++;
      @(posedge i_clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; start = 1'b0; dividend = 4'h0; divisor = 4'h0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({quotient, remainder, overflow, div_by_zero, busy, done} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got q=%h r=%h ov=%b dz=%b busy=%b done=%b, want all 0",
               quotient, remainder, overflow, div_by_zero, busy, done);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, bcnt;
    do_op(4'h7, 4'h2, cyc, bcnt);
    checks++;
    if (cyc !== 7) begin
      failures++; $display("FAIL basic_latency: got %0d, want 7", cyc);
    end
    checks++;
    if ({quotient, remainder, overflow} !== {4'h3, 4'h1, 1'b0}) begin
      failures++;
      $display("FAIL basic_7div2: got q=%h r=%h ov=%b, want q=3 r=1 ov=0",
               quotient, remainder, overflow);
    end
    checks++;
    if (bcnt !== 6 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_busy: got %0d busy cycles (busy@done=%b), want 6 (0)", bcnt, busy);
    end
  endtask

  task automatic test_signs();
    logic [3:0] ta [9] = '{4'h9, 4'h7, 4'h9, 4'h0, 4'h2, 4'hE, 4'h6, 4'h8, 4'h8};
    logic [3:0] tb [9] = '{4'h2, 4'hE, 4'hE, 4'h3, 4'h5, 4'h5, 4'h3, 4'hF, 4'h1};
    logic [3:0] eq [9] = '{4'hD, 4'hD, 4'h3, 4'h0, 4'h0, 4'h0, 4'h2, 4'h8, 4'h8};
    logic [3:0] er [9] = '{4'hF, 4'h1, 4'hF, 4'h0, 4'h2, 4'hE, 4'h0, 4'h0, 4'h0};
    logic       eo [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int cyc, bcnt;
    for (int i = 0; i < 9; i++) begin
      do_op(ta[i], tb[i], cyc, bcnt);
      checks++;
      if (cyc !== 7 || {quotient, remainder, overflow} !== {eq[i], er[i], eo[i]}) begin
        failures++;
        $display("FAIL signed_%h_div_%h: got q=%h r=%h ov=%b cyc=%0d, want q=%h r=%h ov=%b cyc=7",
                 ta[i], tb[i], quotient, remainder, overflow, cyc, eq[i], er[i], eo[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc, bcnt;
    do_op(4'h5, 4'h0, cyc, bcnt);
`ifdef DIV_ZERO_DETECT_EN
    checks++;
    if (cyc !== 3 || bcnt !== 2) begin
      failures++; $display("FAIL dz_latency: got cyc=%0d busy=%0d, want cyc=3 busy=2", cyc, bcnt);
    end
    checks++;
    if ({div_by_zero, quotient, remainder, overflow} !== {1'b1, 4'hF, 4'h5, 1'b0}) begin
      failures++;
      $display("FAIL dz_result: got dz=%b q=%h r=%h ov=%b, want dz=1 q=f r=5 ov=0",
               div_by_zero, quotient, remainder, overflow);
    end
`else
    checks++;
    if (cyc !== 7 || bcnt !== 6) begin
      failures++; $display("FAIL dz_latency: got cyc=%0d busy=%0d, want cyc=7 busy=6", cyc, bcnt);
    end
    checks++;
    if ({div_by_zero, quotient, remainder} !== {1'b0, 4'hF, 4'h5}) begin
      failures++;
      $display("FAIL dz_result: got dz=%b q=%h r=%h, want dz=0 q=f r=5",
               div_by_zero, quotient, remainder);
    end
`endif
  endtask

  task automatic test_start_hold();
    int cyc, bcnt, gaps, extra;
    @(posedge i_clk); #1;
    start = 1'b1; dividend = 4'h7; divisor = 4'h2;
    @(posedge i_clk); #1;
    dividend = 4'h1; divisor = 4'h1;
    cyc = 1; bcnt = 0; gaps = 0; extra = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (busy === 1'b1) bcnt++; else gaps++;
      @(posedge i_clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== 7 || {quotient, remainder} !== {4'h3, 4'h1}) begin
      failures++;
      $display("FAIL hold_no_recapture: got q=%h r=%h cyc=%0d, want q=3 r=1 cyc=7",
               quotient, remainder, cyc);
    end
    checks++;
    if (bcnt !== 6 || gaps !== 0) begin
      failures++; $display("FAIL hold_busy_contig: got busy=%0d gaps=%0d, want busy=6 gaps=0", bcnt, gaps);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++; $display("FAIL hold_single_done: got %0d extra active cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int first, second, ndone, guard;
    first = -1; second = -1; ndone = 0;
    @(posedge i_clk); #1;
    start = 1'b1; dividend = 4'h9; divisor = 4'h2;
    @(posedge i_clk); #1;
    for (int c = 1; c <= 20; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
        else if (second < 0) begin
          second = c;
          checks++;
          if ({quotient, remainder} !== {4'hD, 4'hF}) begin
            failures++;
            $display("FAIL b2b_result: got q=%h r=%h, want q=d r=f", quotient, remainder);
          end
        end
      end
      @(posedge i_clk); #1;
    end
    start = 1'b0;
    checks++;
    if (first !== 7 || second !== 15 || ndone !== 2) begin
      failures++;
      $display("FAIL b2b_spacing: got dones at %0d,%0d count %0d, want 7,15 count 2",
               first, second, ndone);
    end
    guard = 0;
    while ((busy === 1'b1 || done === 1'b1) && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++; $display("FAIL b2b_drain: got still busy after %0d cycles, want idle", guard);
    end
  endtask

  task automatic test_reset_midop();
    int cyc, bcnt, extra;
    @(posedge i_clk); #1;
    start = 1'b1; dividend = 4'h6; divisor = 4'h3;
    @(posedge i_clk); #1;
    start = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if ({quotient, remainder, overflow, div_by_zero, busy, done} !== 12'h000) begin
      failures++;
      $display("FAIL midop_reset: got q=%h r=%h ov=%b dz=%b busy=%b done=%b, want all 0",
               quotient, remainder, overflow, div_by_zero, busy, done);
    end
    i_rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++; $display("FAIL midop_abort: got %0d active cycles after reset, want 0", extra);
    end
    do_op(4'h6, 4'h3, cyc, bcnt);
    checks++;
    if (cyc !== 7 || {quotient, remainder, overflow} !== {4'h2, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL midop_rerun: got q=%h r=%h ov=%b cyc=%0d, want q=2 r=0 ov=0 cyc=7",
               quotient, remainder, overflow, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_start_hold();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
